// File: rtl/keypad_scanner.sv
// keypad_scanner: column-strobing scanner for a 4x4 active-low matrix keypad.
// Drives one active-low column per slot, samples the rows at the end of each
// slot, debounces press and release over DEBOUNCE_SCANS consecutive slot ticks,
// and reports the accepted key as row*4 + col with a one-cycle valid pulse.
module keypad_scanner #(
    parameter int SCAN_DIV       = 27000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] row_in,
    output logic [3:0] col_out,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int PW = $clog2(SCAN_DIV);
    localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] CNT_TARGET = CW'(DEBOUNCE_SCANS);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO   = CW'(0);

    typedef enum logic [1:0] {
        ST_SCAN     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_ACCEPT   = 2'd2,
        ST_HOLD     = 2'd3
    } state_t;

    // Active-low one-hot column strobe for a column index.
    function automatic logic [3:0] col_strobe(input logic [1:0] idx);
        return ~(4'b0001 << idx);
    endfunction

    // Lowest-index low row wins when several rows read low.
    function automatic logic [1:0] encode_row(input logic [3:0] rows_low);
        logic [1:0] enc;
        if (rows_low[0]) begin
            enc = 2'd0;
        end else if (rows_low[1]) begin
            enc = 2'd1;
        end else if (rows_low[2]) begin
            enc = 2'd2;
        end else begin
            enc = 2'd3;
        end
        return enc;
    endfunction

    state_t         state_r;
    state_t         state_s;
    logic [PW-1:0]  presc_r;
    logic           tick_s;
    logic [1:0]     col_idx_r;
    logic [1:0]     col_idx_s;
    logic [3:0]     col_out_r;
    logic [3:0]     col_out_s;
    logic [1:0]     cand_row_r;
    logic [1:0]     cand_row_s;
    logic [1:0]     cand_col_r;
    logic [1:0]     cand_col_s;
    logic [CW-1:0]  cnt_r;
    logic [CW-1:0]  cnt_s;
    logic [3:0]     key_code_r;
    logic [3:0]     key_code_s;
    logic           key_valid_r;
    logic           key_valid_s;
    logic           key_held_r;
    logic           key_held_s;
    logic           any_low_s;
    logic [1:0]     enc_row_s;

    assign tick_s    = (presc_r == PRESC_LAST);
    assign any_low_s = (row_in != 4'b1111);
    assign enc_row_s = encode_row(~row_in);

    assign col_out   = col_out_r;
    assign key_code  = key_code_r;
    assign key_valid = key_valid_r;
    assign key_held  = key_held_r;

    // Slot prescaler: wraps at SCAN_DIV-1, the wrap cycle is the sampling tick.
    always_ff @(posedge clk) begin
        if (reset) begin
            presc_r <= {PW{1'b0}};
        end else if (tick_s) begin
            presc_r <= {PW{1'b0}};
        end else begin
            presc_r <= presc_r + PW'(1);
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_SCAN;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state and datapath decisions; rows are only acted on at ticks.
    always_comb begin
        state_s     = state_r;
        col_idx_s   = col_idx_r;
        cand_row_s  = cand_row_r;
        cand_col_s  = cand_col_r;
        cnt_s       = cnt_r;
        key_code_s  = key_code_r;
        key_valid_s = 1'b0;
        key_held_s  = key_held_r;
        case (state_r)
            ST_SCAN: begin
                if (tick_s && any_low_s) begin
                    cand_row_s = enc_row_s;
                    cand_col_s = col_idx_r;
                    if (CNT_TARGET == CNT_ONE) begin
                        state_s     = ST_ACCEPT;
                        key_code_s  = {enc_row_s, col_idx_r};
                        key_valid_s = 1'b1;
                        key_held_s  = 1'b1;
                        cnt_s       = CNT_ZERO;
                    end else begin
                        state_s = ST_DEBOUNCE;
                        cnt_s   = CNT_ONE;
                    end
                end else if (tick_s) begin
                    col_idx_s = col_idx_r + 2'd1;
                end else begin
                    state_s = ST_SCAN;
                end
            end
            ST_DEBOUNCE: begin
                if (tick_s && any_low_s && (enc_row_s == cand_row_r)) begin
                    if ((cnt_r + CNT_ONE) == CNT_TARGET) begin
                        state_s     = ST_ACCEPT;
                        key_code_s  = {cand_row_r, cand_col_r};
                        key_valid_s = 1'b1;
                        key_held_s  = 1'b1;
                        cnt_s       = CNT_ZERO;
                    end else begin
                        cnt_s = cnt_r + CNT_ONE;
                    end
                end else if (tick_s) begin
                    state_s   = ST_SCAN;
                    cnt_s     = CNT_ZERO;
                    col_idx_s = col_idx_r + 2'd1;
                end else begin
                    state_s = ST_DEBOUNCE;
                end
            end
            ST_ACCEPT: begin
                // The valid pulse is already on the output during this cycle.
                state_s = ST_HOLD;
                cnt_s   = CNT_ZERO;
            end
            ST_HOLD: begin
                if (tick_s && !any_low_s) begin
                    if ((cnt_r + CNT_ONE) == CNT_TARGET) begin
                        state_s    = ST_SCAN;
                        key_held_s = 1'b0;
                        cnt_s      = CNT_ZERO;
                        col_idx_s  = col_idx_r + 2'd1;
                    end else begin
                        cnt_s = cnt_r + CNT_ONE;
                    end
                end else if (tick_s) begin
                    // Any low row, even another key in this column, restarts release.
                    cnt_s = CNT_ZERO;
                end else begin
                    state_s = ST_HOLD;
                end
            end
            default: begin
                state_s    = ST_SCAN;
                cnt_s      = CNT_ZERO;
                key_held_s = 1'b0;
            end
        endcase
        col_out_s = col_strobe(col_idx_s);
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            col_idx_r   <= 2'd0;
            col_out_r   <= 4'b1110;
            cand_row_r  <= 2'd0;
            cand_col_r  <= 2'd0;
            cnt_r       <= CNT_ZERO;
            key_code_r  <= 4'd0;
            key_valid_r <= 1'b0;
            key_held_r  <= 1'b0;
        end else begin
            col_idx_r   <= col_idx_s;
            col_out_r   <= col_out_s;
            cand_row_r  <= cand_row_s;
            cand_col_r  <= cand_col_s;
            cnt_r       <= cnt_s;
            key_code_r  <= key_code_s;
            key_valid_r <= key_valid_s;
            key_held_r  <= key_held_s;
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed bench with a keypad matrix model and a
// key-code scoreboard drained by an independent valid-pulse monitor.
module tb_keypad_scanner;

    logic        clk;
    logic        reset;
    logic [3:0]  row_in;
    logic [3:0]  col_out;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_held;

    logic [15:0] pressed;      // bit r*4+c set when key(r,c) is down
    logic [3:0]  exp_q[$];
    int          tests_run;
    int          failed;
    logic        prev_valid;

    keypad_scanner #(
        .SCAN_DIV      (4),
        .DEBOUNCE_SCANS(3)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .row_in   (row_in),
        .col_out  (col_out),
        .key_code (key_code),
        .key_valid(key_valid),
        .key_held (key_held)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Matrix model: a row is pulled low by any pressed key in a strobed column.
    always_comb begin
        row_in = 4'b1111;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (pressed[r*4+c] && (col_out[c] == 1'b0)) begin
                    row_in[r] = 1'b0;
                end
            end
        end
    end

    // Monitor: every valid pulse pops one expected code; pulses are one cycle wide.
    always @(negedge clk) begin
        if (key_valid) begin
            tests_run++;
            if (exp_q.size() == 0) begin
                failed++;
                $display("FAIL sb_unexpected_pulse: got code %0d, expected no pulse", key_code);
            end else begin
                logic [3:0] e;
                e = exp_q.pop_front();
                if (key_code !== e || key_held !== 1'b1) begin
                    failed++;
                    $display("FAIL sb_code: got code %0d held %b, expected code %0d held 1",
                             key_code, key_held, e);
                end
            end
            if (prev_valid) begin
                failed++;
                $display("FAIL sb_pulse_width: got valid high two cycles, expected one");
            end
        end
        prev_valid = key_valid;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic next_tick();
        repeat (4) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Bounded wait for key_held to rise; leaves us at the negedge after the tick.
    task automatic wait_held(input string name);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (key_held) begin
                ok = 1'b1;
                break;
            end
        end
        check(name, {31'd0, ok}, 32'd1);
    endtask

    initial begin
        logic [3:0] steps [4];
        steps[0] = 4'b1101;
        steps[1] = 4'b1011;
        steps[2] = 4'b0111;
        steps[3] = 4'b1110;
        tests_run  = 0;
        failed     = 0;
        prev_valid = 1'b0;
        pressed    = 16'd0;
        reset      = 1'b0;

        // 1: reset values, then free-running column rotation every 4 clocks.
        do_reset();
        check("rst_col", {28'd0, col_out}, 32'hE);
        check("rst_valid", {31'd0, key_valid}, 32'd0);
        check("rst_held", {31'd0, key_held}, 32'd0);
        check("rst_code", {28'd0, key_code}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            next_tick();
            check("scan_step", {28'd0, col_out}, {28'd0, steps[i]});
        end

        // 2: key(1,2) pressed; accepted on the cycle after the 3rd matching tick.
        exp_q.push_back(4'd6);
        pressed = 16'd1 << 6;
        repeat (19) @(posedge clk);
        @(negedge clk);
        check("lat_early", {31'd0, key_valid}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("lat_pulse", {31'd0, key_valid}, 32'd1);
        check("lat_code", {28'd0, key_code}, 32'd6);
        @(posedge clk);
        @(negedge clk);
        check("pulse_end", {31'd0, key_valid}, 32'd0);
        check("hold_held", {31'd0, key_held}, 32'd1);
        check("hold_col", {28'd0, col_out}, 32'hB);
        repeat (3) @(posedge clk);
        @(negedge clk);

        // 5: release debounce; a low row (other key, same column) restarts it.
        pressed = 16'd0;
        next_tick();
        next_tick();
        check("rel_partial", {31'd0, key_held}, 32'd1);
        pressed = 16'd1 << 10;
        next_tick();
        pressed = 16'd0;
        next_tick();
        next_tick();
        check("rel_restart", {31'd0, key_held}, 32'd1);
        next_tick();
        check("rel_done_held", {31'd0, key_held}, 32'd0);
        check("rel_done_col", {28'd0, col_out}, 32'h7);
        check("rel_code_kept", {28'd0, key_code}, 32'd6);

        // 3: one-tick glitch on key(1,2) is rejected and scanning resumes.
        pressed = 16'd1 << 6;
        next_tick();
        next_tick();
        next_tick();
        check("short_col2", {28'd0, col_out}, 32'hB);
        next_tick();
        check("short_frozen", {28'd0, col_out}, 32'hB);
        pressed = 16'd0;
        next_tick();
        check("short_resume", {28'd0, col_out}, 32'h7);
        check("short_no_held", {31'd0, key_held}, 32'd0);

        // 4: key(0,1) and key(3,1) together; lowest row wins, row 3 never reported.
        exp_q.push_back(4'd1);
        pressed = (16'd1 << 1) | (16'd1 << 13);
        wait_held("dual_wait");
        check("dual_code", {28'd0, key_code}, 32'd1);
        check("dual_col", {28'd0, col_out}, 32'hD);
        next_tick();
        next_tick();
        next_tick();
        pressed = 16'd1 << 13;
        repeat (4) next_tick();
        check("other_row_held", {31'd0, key_held}, 32'd1);
        check("other_row_code", {28'd0, key_code}, 32'd1);
        pressed = 16'd0;
        repeat (3) next_tick();
        check("dual_rel_held", {31'd0, key_held}, 32'd0);
        check("dual_rel_col", {28'd0, col_out}, 32'hB);

        // 6: reset while holding, then the still-held key is accepted afresh.
        exp_q.push_back(4'd6);
        pressed = 16'd1 << 6;
        wait_held("pre_rst_wait");
        check("pre_rst_code", {28'd0, key_code}, 32'd6);
        next_tick();
        do_reset();
        check("mid_rst_col", {28'd0, col_out}, 32'hE);
        check("mid_rst_held", {31'd0, key_held}, 32'd0);
        check("mid_rst_code", {28'd0, key_code}, 32'd0);
        check("mid_rst_valid", {31'd0, key_valid}, 32'd0);
        exp_q.push_back(4'd6);
        wait_held("fresh_wait");
        check("fresh_code", {28'd0, key_code}, 32'd6);
        check("fresh_col", {28'd0, col_out}, 32'hB);
        pressed = 16'd0;
        repeat (3) next_tick();
        check("fresh_rel", {31'd0, key_held}, 32'd0);

        repeat (10) @(posedge clk);
        @(negedge clk);
        check("sb_drained", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got no finish by 200000, expected earlier finish");
        $fatal(1, "watchdog expired");
    end

endmodule
